// File: rtl/pixel_enhance_stream.sv
// Streaming per-channel pixel enhancement with frame sequencing.
// Applies one of several point operations to each pixel beat.
// The beat is registered once, with valid/ready handshakes on both sides.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for the first start
// RUN    | frame in progress, accepting and delivering pixel beats
// DONE   | all TOTAL_PIXELS beats delivered, waiting for the next start
module pixel_enhance_stream #(
  parameter int DATA_W       = 8,
  parameter int CHANNELS     = 3,
  parameter int TOTAL_PIXELS = 120000,
  parameter int CNT_W        = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [2:0]                   mode,
  input  logic [DATA_W-1:0]            param_val,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         busy,
  output logic                         done,
  output logic [CNT_W-1:0]             pixel_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0]  TOTAL_C = CNT_W'(TOTAL_PIXELS);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(TOTAL_PIXELS - 1);
  localparam logic [DATA_W-1:0] MAX_C   = {DATA_W{1'b1}};

  state_t                       state_q, state_d;
  logic [2:0]                   mode_q;
  logic [DATA_W-1:0]            param_q;
  logic [CNT_W-1:0]             acc_cnt_q;
  logic                         start_frame;
  logic                         in_fire;
  logic                         out_fire;
  logic                         last_out;
  logic [CHANNELS*DATA_W-1:0]   result;

  // Contrast gain is unsigned Q4.4, so the full product is kept before the
  // shift and only clamped afterwards.
  function automatic logic [DATA_W-1:0] enhance(input logic [DATA_W-1:0] x,
                                                input logic [2:0]        m,
                                                input logic [DATA_W-1:0] p);
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] scaled;
    logic [DATA_W-1:0]   res;
    sum    = {1'b0, x} + {1'b0, p};
    prod   = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, p};
    scaled = prod >> 4;
    case (m)
      3'b001:  res = sum[DATA_W] ? MAX_C : sum[DATA_W-1:0];
      3'b010:  res = (x >= p) ? (x - p) : '0;
      3'b011:  res = (x >= p) ? MAX_C : '0;
      3'b100:  res = MAX_C - x;
      3'b101:  res = (|scaled[2*DATA_W-1:DATA_W]) ? MAX_C : scaled[DATA_W-1:0];
      default: res = x;
    endcase
    return res;
  endfunction

  assign start_frame = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign last_out    = (state_q == S_RUN) && out_fire && (pixel_count == LAST_C);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a start coinciding with the last delivery is ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)    state_d = S_RUN;
      S_RUN:   if (last_out) state_d = S_DONE;
      S_DONE:  if (start)    state_d = S_RUN;
      default:               state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; input throttled by frame budget and output slot
  always_comb begin
    busy     = (state_q == S_RUN);
    done     = (state_q == S_DONE);
    in_ready = (state_q == S_RUN) && (acc_cnt_q < TOTAL_C) && (!out_valid || out_ready);
  end

  // Per-channel operation on the incoming beat
  always_comb begin
    result = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      result[c*DATA_W +: DATA_W] = enhance(in_data[c*DATA_W +: DATA_W], mode_q, param_q);
    end
  end

  // Operation and operand are frozen for the whole frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= 3'b000;
      param_q <= '0;
    end else if (start_frame) begin
      mode_q  <= mode;
      param_q <= param_val;
    end
  end

  // Accepted and delivered beat counters, cleared at each frame start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_cnt_q   <= '0;
      pixel_count <= '0;
    end else if (start_frame) begin
      acc_cnt_q   <= '0;
      pixel_count <= '0;
    end else begin
      if (in_fire)  acc_cnt_q   <= acc_cnt_q + 1'b1;
      if (out_fire) pixel_count <= pixel_count + 1'b1;
    end
  end

  // Single output register; holds its beat while downstream stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (start_frame) begin
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= result;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_enhance_stream.sv
// Directed bench for pixel_enhance_stream with a 4-beat frame.
module tb_pixel_enhance_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mode;
  logic [7:0]  param_val;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        busy;
  logic        done;
  logic [31:0] pixel_count;

  int n_checks = 0;
  int n_errors = 0;

  pixel_enhance_stream #(
    .DATA_W(8), .CHANNELS(3), .TOTAL_PIXELS(4), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .param_val(param_val),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .pixel_count(pixel_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 4-beat frame with out_ready high, alternating two pixels.
  task automatic run_frame(input string nm, input logic [2:0] m, input logic [7:0] p,
                           input logic [23:0] pa, input logic [23:0] ea,
                           input logic [23:0] pb, input logic [23:0] eb);
    mode = m; param_val = p; start = 1'b1;
    tick();
    start = 1'b0;
    check({nm, " busy"}, busy, 1);
    check({nm, " done"}, done, 0);
    check({nm, " cnt0"}, pixel_count, 0);
    in_valid = 1'b1; in_data = pa;
    #1;
    check({nm, " in_ready"}, in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check({nm, " out_valid"}, out_valid, 1);
      check({nm, " out_data"}, out_data, (i % 2 == 0) ? ea : eb);
      check({nm, " cnt"}, pixel_count, i);
      in_data = (i % 2 == 0) ? pb : pa;
    end
    #1;
    check({nm, " in_ready full"}, in_ready, 0);
    tick();
    check({nm, " done"}, done, 1);
    check({nm, " busy end"}, busy, 0);
    check({nm, " cnt4"}, pixel_count, 4);
    check({nm, " out_valid end"}, out_valid, 0);
    tick();
    check({nm, " extra beat"}, pixel_count, 4);
    check({nm, " done level"}, done, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 3'b000; param_val = 8'h00;
    in_valid = 1'b0; in_data = 24'h0; out_ready = 1'b1;
    #23;
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst in_ready", in_ready, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst cnt", pixel_count, 0);
    tick();
    reset = 1'b1;
    tick();

    // saturating add, channels 0xF0 -> 0xFF and 0x10 -> 0x30
    run_frame("add", 3'b001, 8'h20, 24'hF010F0, 24'hFF30FF, 24'h10F010, 24'h30FF30);

    // contrast x1.5 from DONE, with operands changed mid-frame and a stall
    mode = 3'b101; param_val = 8'h18; start = 1'b1;
    tick();
    start = 1'b0;
    check("con busy", busy, 1);
    check("con done", done, 0);
    check("con cnt0", pixel_count, 0);
    mode = 3'b001; param_val = 8'h00;
    in_valid = 1'b1; in_data = 24'hC04000;
    tick();
    check("con out_valid", out_valid, 1);
    check("con beat0", out_data, 24'hFF6000);
    out_ready = 1'b0; in_data = 24'h204080;
    #1;
    check("stall in_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall out_valid", out_valid, 1);
      check("stall out_data", out_data, 24'hFF6000);
      check("stall cnt", pixel_count, 0);
      check("stall in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("resume in_ready", in_ready, 1);
    tick();
    check("con beat1", out_data, 24'h3060C0);
    check("con cnt1", pixel_count, 1);
    in_data = 24'hC04000; start = 1'b1;
    tick();
    start = 1'b0;
    check("con beat2", out_data, 24'hFF6000);
    check("run start ignored", pixel_count, 2);
    check("run busy", busy, 1);
    in_data = 24'h204080;
    tick();
    check("con beat3", out_data, 24'h3060C0);
    check("con cnt3", pixel_count, 3);
    in_valid = 1'b0;
    mode = 3'b011; param_val = 8'h80; start = 1'b1;
    tick();
    check("last+start done", done, 1);
    check("last+start cnt", pixel_count, 4);
    tick();
    start = 1'b0;
    check("restart busy", busy, 1);
    check("restart cnt", pixel_count, 0);

    // threshold at 0x80, then reset mid-frame with a held beat
    in_valid = 1'b1; in_data = 24'h807F80;
    tick();
    check("thr beat0", out_data, 24'hFF00FF);
    in_data = 24'h00817F;
    tick();
    check("thr beat1", out_data, 24'h00FF00);
    check("thr cnt1", pixel_count, 1);
    in_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("thr held", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid rst out_valid", out_valid, 0);
    check("mid rst out_data", out_data, 0);
    check("mid rst busy", busy, 0);
    check("mid rst done", done, 0);
    check("mid rst cnt", pixel_count, 0);
    check("mid rst in_ready", in_ready, 0);
    tick();
    reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 24'h111111;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("post rst in_ready", in_ready, 0);
      check("post rst busy", busy, 0);
      check("post rst out_valid", out_valid, 0);
    end
    in_valid = 1'b0;

    run_frame("pass6", 3'b110, 8'h55, 24'h123456, 24'h123456, 24'hFFFF00, 24'hFFFF00);
    run_frame("sub", 3'b010, 8'h30, 24'hFF5020, 24'hCF2000, 24'h30312F, 24'h000100);
    run_frame("inv", 3'b100, 8'h00, 24'h00A5FF, 24'hFF5A00, 24'h010203, 24'hFEFDFC);
    run_frame("pass0", 3'b000, 8'hFF, 24'hABCDEF, 24'hABCDEF, 24'h000001, 24'h000001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
